// File: rtl/ahb_mem_resp_q.sv
// AHB-Lite word memory responder with fixed wait states and ERROR
// response for out-of-range addresses; backdoor preload port.
//
// Ports:
//   hclk, hrst        clock, async active-high reset
//   hsel, htrans      slave select, transfer type (bit1 = active)
//   haddr, hwrite     byte address, write enable (address phase)
//   hwdata            write data (data phase)
//   hready            bus-level ready (previous transfer complete)
//   hreadyout, hresp  this slave's ready and OKAY/ERROR response
//   hrdata            read data, valid only in a read's DONE cycle
//   init_en/addr/data backdoor word write
//   wr_count/rd_count saturating counts of OKAY writes/reads
module ahb_mem_resp_q #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic [31:0]   haddr,
  input  logic          hwrite,
  input  logic [31:0]   hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic [31:0]   hrdata,
  output logic          hresp,
  input  logic          init_en,
  input  logic [AW-1:0] init_addr,
  input  logic [31:0]   init_data,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state_q, state_d;
  state_t          start_st;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rdy_q, resp_q;
  logic [15:0]     wr_count_q, rd_count_q;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            oor;
  logic            commit_wr;
  logic            commit_rd;
  logic            unused_ok;

  assign unused_ok = ^{haddr[1:0], htrans[0]};

  assign accept    = hsel & htrans[1] & hready;
  assign oor       = |haddr[31:AW+2];
  assign commit_wr = (state_q == S_DONE) & wr_q;
  assign commit_rd = (state_q == S_DONE) & ~wr_q;

  // Errors skip the wait-state counter entirely.
  always_comb begin
    start_st = S_DONE;
    if (oor) begin
      start_st = S_ERR1;
    end else if (WAIT_STATES > 0) begin
      start_st = S_WAIT;
    end
  end

  function automatic logic rdy_of(state_t s);
    return !((s == S_WAIT) || (s == S_ERR1));
  endfunction

  function automatic logic resp_of(state_t s);
    return (s == S_ERR1) || (s == S_ERR2);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      // IDLE, DONE and ERR2 all end a data phase and may accept.
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = start_st;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = haddr[AW+1:2];
          wr_d    = hwrite;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      rdy_q      <= 1'b1;
      resp_q     <= 1'b0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_of(state_d);
      resp_q  <= resp_of(state_d);
      if (commit_wr && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (commit_rd && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  // Contents survive reset; the later assignment gives the bus
  // write priority over a same-index backdoor write.
  always_ff @(posedge hclk) begin
    if (init_en) begin
      mem[init_addr] <= init_data;
    end
    if (commit_wr) begin
      mem[idx_q] <= hwdata;
    end
  end

  assign hreadyout = rdy_q;
  assign hresp     = resp_q;
  assign hrdata    = commit_rd ? mem[idx_q] : '0;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_ahb_mem_resp_q.sv
// Bench for ahb_mem_resp_q: three instances (0/1/3 wait states),
// directed table, hand sequences and random traffic vs a model.
module tb_ahb_mem_resp_q;

  localparam int AW = 6;

  logic          hclk = 1'b0;
  logic          hrst      [3];
  logic          hsel      [3];
  logic [1:0]    htrans    [3];
  logic [31:0]   haddr     [3];
  logic          hwrite    [3];
  logic [31:0]   hwdata    [3];
  logic          hready    [3];
  logic          hreadyout [3];
  logic [31:0]   hrdata    [3];
  logic          hresp     [3];
  logic          init_en   [3];
  logic [AW-1:0] init_addr [3];
  logic [31:0]   init_data [3];
  logic [15:0]   wr_count  [3];
  logic [15:0]   rd_count  [3];

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    assign hready[g] = hreadyout[g];
    ahb_mem_resp_q #(.DEPTH(64), .WAIT_STATES(WS)) u_dut (
      .hclk     (hclk),
      .hrst     (hrst[g]),
      .hsel     (hsel[g]),
      .htrans   (htrans[g]),
      .haddr    (haddr[g]),
      .hwrite   (hwrite[g]),
      .hwdata   (hwdata[g]),
      .hready   (hready[g]),
      .hreadyout(hreadyout[g]),
      .hrdata   (hrdata[g]),
      .hresp    (hresp[g]),
      .init_en  (init_en[g]),
      .init_addr(init_addr[g]),
      .init_data(init_data[g]),
      .wr_count (wr_count[g]),
      .rd_count (rd_count[g])
    );
  end

  // Transaction-level model: memory image and completed-op counts.
  logic [31:0] mem_m [3][64];
  int          wr_m  [3];
  int          rd_m  [3];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          k;
    logic [31:0] a;
    bit          wr;
    logic [31:0] wd;
    bit          bd;
    int          bdi;
    logic [31:0] bdd;
    bit          e_err;
    int          e_lat;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [13];

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  function automatic logic [31:0] sat(int x);
    return (x > 65535) ? 32'd65535 : 32'(x);
  endfunction

  function automatic vec_t row(int k, logic [31:0] a, bit wr,
                               logic [31:0] wd, bit bd, int bdi,
                               logic [31:0] bdd, bit e_err,
                               int e_lat, logic [31:0] e_rd);
    vec_t v;
    v.k = k; v.a = a; v.wr = wr; v.wd = wd;
    v.bd = bd; v.bdi = bdi; v.bdd = bdd;
    v.e_err = e_err; v.e_lat = e_lat; v.e_rd = e_rd;
    return v;
  endfunction

  // Expected response straight from the model's rules.
  function automatic vec_t mk(int k, logic [31:0] a, bit wr,
                              logic [31:0] wd, bit bd, int bdi,
                              logic [31:0] bdd);
    bit oor;
    logic [31:0] r;
    oor = (a >= 32'd256);
    r = (oor || wr) ? 32'h0 : mem_m[k][a[7:2]];
    return row(k, a, wr, wd, bd, bdi, bdd, oor,
               oor ? 2 : ws_of(k) + 1, r);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int k, input logic [31:0] a, input bit wr,
                      input logic [31:0] wd, input bit bd,
                      input int bdi, input logic [31:0] bdd,
                      output bit err, output int lat,
                      output logic [31:0] rd);
    @(negedge hclk);
    hsel[k] = 1'b1; htrans[k] = 2'b10;
    haddr[k] = a; hwrite[k] = wr;
    @(posedge hclk); #1;
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwdata[k] = wd;
    lat = 1;
    while (!hreadyout[k] && lat < 40) begin
      @(posedge hclk); #1;
      lat++;
    end
    err = hresp[k];
    rd  = hrdata[k];
    if (bd) begin
      init_en[k] = 1'b1;
      init_addr[k] = AW'(bdi);
      init_data[k] = bdd;
    end
    @(posedge hclk); #1;
    init_en[k] = 1'b0;
  endtask

  task automatic apply(vec_t v, string tag);
    bit err;
    int lat;
    logic [31:0] rd;
    xfer(v.k, v.a, v.wr, v.wd, v.bd, v.bdi, v.bdd, err, lat, rd);
    chk({tag, " lat"}, lat, v.e_lat);
    chk({tag, " resp"}, 32'(err), 32'(v.e_err));
    chk({tag, " rdata"}, rd, v.e_rd);
    if (v.bd) mem_m[v.k][v.bdi] = v.bdd;
    if (v.a < 32'd256) begin
      if (v.wr) begin
        mem_m[v.k][v.a[7:2]] = v.wd;
        wr_m[v.k]++;
      end else begin
        rd_m[v.k]++;
      end
    end
    chk({tag, " wr_count"}, 32'(wr_count[v.k]), sat(wr_m[v.k]));
    chk({tag, " rd_count"}, 32'(rd_count[v.k]), sat(rd_m[v.k]));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      hrst[k] = 1'b1; hsel[k] = 1'b0; htrans[k] = 2'b00;
      haddr[k] = '0; hwrite[k] = 1'b0; hwdata[k] = '0;
      init_en[k] = 1'b0; init_addr[k] = '0; init_data[k] = '0;
      wr_m[k] = 0; rd_m[k] = 0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d rdy", k), 32'(hreadyout[k]), 32'd1);
      chk($sformatf("rst%0d resp", k), 32'(hresp[k]), 32'd0);
      chk($sformatf("rst%0d rdata", k), hrdata[k], 32'd0);
      chk($sformatf("rst%0d wrc", k), 32'(wr_count[k]), 32'd0);
      chk($sformatf("rst%0d rdc", k), 32'(rd_count[k]), 32'd0);
    end
    @(negedge hclk);
    for (int k = 0; k < 3; k++) hrst[k] = 1'b0;

    // Preload every word of every instance through the backdoor.
    for (int i = 0; i < 64; i++) begin
      @(negedge hclk);
      for (int k = 0; k < 3; k++) begin
        mem_m[k][i] = $urandom;
        init_en[k] = 1'b1;
        init_addr[k] = AW'(i);
        init_data[k] = mem_m[k][i];
      end
      if (i == 63) begin
        @(negedge hclk);
        mem_m[1][1] = 32'habcd52c2; mem_m[1][2] = 32'hf9c6f303;
        mem_m[1][3] = 32'h030f8303; mem_m[1][4] = 32'h1ab61040;
        for (int j = 1; j <= 4; j++) begin
          init_addr[1] = AW'(j);
          init_data[1] = mem_m[1][j];
          @(negedge hclk);
        end
      end
    end
    for (int k = 0; k < 3; k++) init_en[k] = 1'b0;

    // Zero-wait pipelined write then read of the same word.
    @(negedge hclk);
    hsel[0] = 1'b1; htrans[0] = 2'b10;
    haddr[0] = 32'h20; hwrite[0] = 1'b1;
    @(posedge hclk); #1;
    chk("pipe wr rdy", 32'(hreadyout[0]), 32'd1);
    chk("pipe wr resp", 32'(hresp[0]), 32'd0);
    hwdata[0] = 32'hEC91CEF5; hwrite[0] = 1'b0;
    @(posedge hclk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    chk("pipe rd rdy", 32'(hreadyout[0]), 32'd1);
    chk("pipe rd resp", 32'(hresp[0]), 32'd0);
    chk("pipe rd data", hrdata[0], 32'hEC91CEF5);
    @(posedge hclk); #1;
    mem_m[0][8] = 32'hEC91CEF5;
    wr_m[0]++; rd_m[0]++;
    chk("pipe wrc", 32'(wr_count[0]), 32'd1);
    chk("pipe rdc", 32'(rd_count[0]), 32'd1);

    tbl[0]  = row(1, 32'd6,  1'b0, 0, 1'b0, 0, 0, 1'b0, 2, 32'habcd52c2);
    tbl[1]  = row(1, 32'd10, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2, 32'hf9c6f303);
    tbl[2]  = row(1, 32'd14, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2, 32'h030f8303);
    tbl[3]  = row(1, 32'd18, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2, 32'h1ab61040);
    tbl[4]  = row(0, 32'h14, 1'b1, 32'h55555555,
                  1'b1, 5, 32'hAAAAAAAA, 1'b0, 1, 32'h0);
    tbl[5]  = row(0, 32'h14, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1, 32'h55555555);
    tbl[6]  = row(0, 32'h18, 1'b1, 32'h11112222,
                  1'b1, 7, 32'h33334444, 1'b0, 1, 32'h0);
    tbl[7]  = row(0, 32'h1C, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1, 32'h33334444);
    tbl[8]  = row(0, 32'h18, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1, 32'h11112222);
    tbl[9]  = row(2, 32'h200, 1'b0, 0, 1'b0, 0, 0, 1'b1, 2, 32'h0);
    tbl[10] = row(2, 32'hFC, 1'b1, 32'hCAFEF00D,
                  1'b0, 0, 0, 1'b0, 4, 32'h0);
    tbl[11] = row(2, 32'hFF, 1'b0, 0, 1'b0, 0, 0, 1'b0, 4, 32'hCAFEF00D);
    tbl[12] = row(1, 32'hFFFFFFFC, 1'b0, 0, 1'b0, 0, 0, 1'b1, 2, 32'h0);
    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    chk("ws1 rdc", 32'(rd_count[1]), 32'd4);
    chk("ws1 wrc", 32'(wr_count[1]), 32'd0);

    // Out-of-range write, then a read accepted during ERR2.
    @(negedge hclk);
    hsel[0] = 1'b1; htrans[0] = 2'b10;
    haddr[0] = 32'h100; hwrite[0] = 1'b1;
    @(posedge hclk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'hDEADBEEF;
    chk("err1 rdy", 32'(hreadyout[0]), 32'd0);
    chk("err1 resp", 32'(hresp[0]), 32'd1);
    @(posedge hclk); #1;
    chk("err2 rdy", 32'(hreadyout[0]), 32'd1);
    chk("err2 resp", 32'(hresp[0]), 32'd1);
    chk("err2 rdata", hrdata[0], 32'd0);
    hsel[0] = 1'b1; htrans[0] = 2'b10;
    haddr[0] = 32'h0; hwrite[0] = 1'b0;
    @(posedge hclk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    chk("erd rdy", 32'(hreadyout[0]), 32'd1);
    chk("erd resp", 32'(hresp[0]), 32'd0);
    chk("erd data", hrdata[0], mem_m[0][0]);
    @(posedge hclk); #1;
    rd_m[0]++;
    chk("err wrc", 32'(wr_count[0]), sat(wr_m[0]));
    chk("err rdc", 32'(rd_count[0]), sat(rd_m[0]));

    // htrans IDLE with hsel high: no transfer.
    @(negedge hclk);
    hsel[1] = 1'b1; htrans[1] = 2'b00;
    haddr[1] = 32'h8; hwrite[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge hclk); #1;
      chk($sformatf("idle%0d rdy", c), 32'(hreadyout[1]), 32'd1);
      chk($sformatf("idle%0d resp", c), 32'(hresp[1]), 32'd0);
    end
    hsel[1] = 1'b0; hwrite[1] = 1'b0;
    chk("idle wrc", 32'(wr_count[1]), sat(wr_m[1]));
    chk("idle rdc", 32'(rd_count[1]), sat(rd_m[1]));

    // Reset in the 2nd wait cycle of a 3-wait write.
    @(negedge hclk);
    hsel[2] = 1'b1; htrans[2] = 2'b10;
    haddr[2] = 32'h10; hwrite[2] = 1'b1;
    @(posedge hclk); #1;
    hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 32'h12345678;
    chk("mrst w1 rdy", 32'(hreadyout[2]), 32'd0);
    @(posedge hclk); #1;
    chk("mrst w2 rdy", 32'(hreadyout[2]), 32'd0);
    #2 hrst[2] = 1'b1;
    #1;
    chk("mrst rdy", 32'(hreadyout[2]), 32'd1);
    chk("mrst resp", 32'(hresp[2]), 32'd0);
    chk("mrst rdata", hrdata[2], 32'd0);
    chk("mrst wrc", 32'(wr_count[2]), 32'd0);
    chk("mrst rdc", 32'(rd_count[2]), 32'd0);
    @(negedge hclk);
    hrst[2] = 1'b0;
    wr_m[2] = 0; rd_m[2] = 0;
    apply(mk(2, 32'h10, 1'b0, 0, 1'b0, 0, 0), "mrst rd");

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      int k;
      int sel;
      logic [31:0] a;
      bit wr;
      bit bd;
      int bdi;
      k = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel == 0) a = 32'h100 + $urandom_range(0, 32'hFFFF);
      else if (sel == 1) a = $urandom;
      else a = $urandom_range(0, 255);
      wr = 1'($urandom_range(0, 1));
      bd = ($urandom_range(0, 5) == 0);
      bdi = $urandom_range(0, 1) ? int'(a[7:2]) : $urandom_range(0, 63);
      apply(mk(k, a, wr, $urandom, bd, bdi, $urandom),
            $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
